// File: rtl/axi_pkg.sv
// AXI type definitions shared by the burst splitter blocks.
package axi_pkg;

  typedef logic [7:0] len_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [3:0] id;
    resp_t      resp;
    logic [0:0] user;
  } b_chan_t;

endpackage

// File: rtl/axi_burst_splitter_b_chan.sv
// B-channel half of the burst splitter: absorbs per-sub-burst write responses
// and returns one merged response upstream once the per-ID counter reaches zero.
module axi_burst_splitter_b_chan #(
  parameter type         chan_t  = axi_pkg::b_chan_t,
  parameter int unsigned IdWidth = 4,
  parameter type         id_t    = logic [IdWidth-1:0]
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  chan_t          b_i,
  input  logic           b_valid_i,
  output logic           b_ready_o,
  output chan_t          b_o,
  output logic           b_valid_o,
  input  logic           b_ready_i,
  output id_t            cnt_id_o,
  input  axi_pkg::len_t  cnt_len_i,
  output logic           cnt_set_err_o,
  input  logic           cnt_err_i,
  output logic           cnt_dec_o,
  output logic           cnt_req_o,
  input  logic           cnt_gnt_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  logic [1:0] state_q, state_d;
  chan_t      b_q, b_d;
  logic       last_access;

  assign last_access = (cnt_len_i == '0);
  assign cnt_id_o    = id_t'(b_q.id);

  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    b_ready_o     = 1'b0;
    b_valid_o     = 1'b0;
    b_o           = '0;
    cnt_req_o     = 1'b0;
    cnt_dec_o     = 1'b0;
    cnt_set_err_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          b_d     = b_i;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        cnt_req_o     = 1'b1;
        cnt_dec_o     = 1'b1;
        // On the final access the error is folded into the merged resp instead.
        cnt_set_err_o = b_q.resp[1] & ~last_access;
        if (cnt_gnt_i) begin
          if (!last_access) begin
            state_d = ST_IDLE;
          end else begin
            // Exclusive access is never split, so EXOKAY collapses to OKAY.
            if (!b_q.resp[1]) begin
              b_d.resp = cnt_err_i ? axi_pkg::RESP_SLVERR : axi_pkg::RESP_OKAY;
            end
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        b_valid_o = 1'b1;
        b_o       = b_q;
        if (b_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_splitter_b_chan.sv
// Directed bench for the burst splitter B channel.
module tb_axi_burst_splitter_b_chan;
  import axi_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  b_chan_t    b_i;
  logic       b_valid_i;
  logic       b_ready_o;
  b_chan_t    b_o;
  logic       b_valid_o;
  logic       b_ready_i;
  logic [3:0] cnt_id_o;
  len_t       cnt_len_i;
  logic       cnt_set_err_o;
  logic       cnt_err_i;
  logic       cnt_dec_o;
  logic       cnt_req_o;
  logic       cnt_gnt_i;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned up_cnt = 0;
  int unsigned dec_cnt = 0;

  always #5 clk_i = ~clk_i;

  axi_burst_splitter_b_chan #(
    .chan_t  (b_chan_t),
    .IdWidth (4),
    .id_t    (logic [3:0])
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .b_i           (b_i),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .b_o           (b_o),
    .b_valid_o     (b_valid_o),
    .b_ready_i     (b_ready_i),
    .cnt_id_o      (cnt_id_o),
    .cnt_len_i     (cnt_len_i),
    .cnt_set_err_o (cnt_set_err_o),
    .cnt_err_i     (cnt_err_i),
    .cnt_dec_o     (cnt_dec_o),
    .cnt_req_o     (cnt_req_o),
    .cnt_gnt_i     (cnt_gnt_i)
  );

  always @(posedge clk_i) begin
    if (b_valid_o && b_ready_i) up_cnt++;
    if (cnt_req_o && cnt_gnt_i && cnt_dec_o) dec_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic b_chan_t mk(input logic [3:0] id, input resp_t r, input logic u);
    b_chan_t b;
    b.id   = id;
    b.resp = r;
    b.user = u;
    return b;
  endfunction

  task automatic beat_in(input b_chan_t b);
    @(negedge clk_i);
    b_i = b; b_valid_i = 1'b1;
    #1;
    check("idle_ready", 32'(b_ready_o), 32'd1);
    check("idle_no_valid", 32'(b_valid_o), 32'd0);
    check("idle_no_req", 32'(cnt_req_o), 32'd0);
    @(posedge clk_i); #1;
    b_valid_i = 1'b0; b_i = '0;
  endtask

  task automatic lookup(input logic [3:0] id, input int unsigned len, input logic err,
                        input logic exp_set_err);
    @(negedge clk_i);
    cnt_len_i = len_t'(len); cnt_err_i = err; cnt_gnt_i = 1'b1;
    #1;
    check("lk_req", 32'(cnt_req_o), 32'd1);
    check("lk_dec", 32'(cnt_dec_o), 32'd1);
    check("lk_id", 32'(cnt_id_o), 32'(id));
    check("lk_set_err", 32'(cnt_set_err_o), 32'(exp_set_err));
    check("lk_not_ready", 32'(b_ready_o), 32'd0);
    check("lk_no_valid", 32'(b_valid_o), 32'd0);
    @(posedge clk_i); #1;
    cnt_gnt_i = 1'b0; cnt_err_i = 1'b0; cnt_len_i = '0;
  endtask

  task automatic expect_out(input b_chan_t exp, input int unsigned stall);
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk_i); #1;
      check("stall_valid", 32'(b_valid_o), 32'd1);
      check("stall_b_o", 32'(b_o), 32'(exp));
      check("stall_not_ready", 32'(b_ready_o), 32'd0);
    end
    @(negedge clk_i);
    b_ready_i = 1'b1;
    #1;
    check("send_valid", 32'(b_valid_o), 32'd1);
    check("send_b_o", 32'(b_o), 32'(exp));
    check("send_not_ready", 32'(b_ready_o), 32'd0);
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
    check("post_send_valid", 32'(b_valid_o), 32'd0);
    check("post_send_b_o", 32'(b_o), 32'd0);
    check("post_send_ready", 32'(b_ready_o), 32'd1);
  endtask

  initial begin
    int unsigned up0, dec0;
    rst_ni = 1'b0; b_i = '0; b_valid_i = 1'b0; b_ready_i = 1'b0;
    cnt_len_i = '0; cnt_err_i = 1'b0; cnt_gnt_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_ready", 32'(b_ready_o), 32'd1);
    check("rst_valid", 32'(b_valid_o), 32'd0);
    check("rst_req", 32'(cnt_req_o), 32'd0);
    check("rst_dec", 32'(cnt_dec_o), 32'd0);
    check("rst_set_err", 32'(cnt_set_err_o), 32'd0);
    check("rst_b_o", 32'(b_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // Unsplit write.
    up0 = up_cnt; dec0 = dec_cnt;
    beat_in(mk(4'd3, RESP_OKAY, 1'b1));
    lookup(4'd3, 0, 1'b0, 1'b0);
    expect_out(mk(4'd3, RESP_OKAY, 1'b1), 0);
    check("unsplit_resp_cnt", up_cnt - up0, 32'd1);

    // EXOKAY collapses to OKAY.
    beat_in(mk(4'd2, RESP_EXOKAY, 1'b0));
    lookup(4'd2, 0, 1'b0, 1'b0);
    expect_out(mk(4'd2, RESP_OKAY, 1'b0), 0);

    // Split burst of four, all OKAY.
    up0 = up_cnt; dec0 = dec_cnt;
    for (int i = 3; i >= 0; i--) begin
      beat_in(mk(4'd5, RESP_OKAY, 1'b0));
      lookup(4'd5, i, 1'b0, 1'b0);
    end
    expect_out(mk(4'd5, RESP_OKAY, 1'b0), 0);
    check("split_resp_cnt", up_cnt - up0, 32'd1);
    check("split_dec_cnt", dec_cnt - dec0, 32'd4);

    // Error on a middle beat, reported at the end through cnt_err_i.
    beat_in(mk(4'd6, RESP_OKAY, 1'b0));   lookup(4'd6, 3, 1'b0, 1'b0);
    beat_in(mk(4'd6, RESP_SLVERR, 1'b0)); lookup(4'd6, 2, 1'b0, 1'b1);
    beat_in(mk(4'd6, RESP_OKAY, 1'b0));   lookup(4'd6, 1, 1'b1, 1'b0);
    beat_in(mk(4'd6, RESP_OKAY, 1'b0));   lookup(4'd6, 0, 1'b1, 1'b0);
    expect_out(mk(4'd6, RESP_SLVERR, 1'b0), 0);

    // Final beat carries DECERR itself.
    beat_in(mk(4'd7, RESP_OKAY, 1'b1));   lookup(4'd7, 3, 1'b0, 1'b0);
    beat_in(mk(4'd7, RESP_SLVERR, 1'b1)); lookup(4'd7, 2, 1'b0, 1'b1);
    beat_in(mk(4'd7, RESP_OKAY, 1'b1));   lookup(4'd7, 1, 1'b1, 1'b0);
    beat_in(mk(4'd7, RESP_DECERR, 1'b1)); lookup(4'd7, 0, 1'b1, 1'b0);
    expect_out(mk(4'd7, RESP_DECERR, 1'b1), 0);

    // Grant withheld for five cycles.
    dec0 = dec_cnt;
    beat_in(mk(4'd8, RESP_OKAY, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); cnt_len_i = 8'd0; #1;
      check("gstall_req", 32'(cnt_req_o), 32'd1);
      check("gstall_id", 32'(cnt_id_o), 32'd8);
      check("gstall_not_ready", 32'(b_ready_o), 32'd0);
      check("gstall_no_valid", 32'(b_valid_o), 32'd0);
    end
    check("gstall_no_dec", dec_cnt - dec0, 32'd0);
    lookup(4'd8, 0, 1'b0, 1'b0);
    expect_out(mk(4'd8, RESP_OKAY, 1'b0), 0);

    // Upstream backpressure with a new beat waiting.
    beat_in(mk(4'd10, RESP_OKAY, 1'b1));
    lookup(4'd10, 0, 1'b1, 1'b0);
    @(negedge clk_i);
    b_i = mk(4'd9, RESP_OKAY, 1'b0); b_valid_i = 1'b1;
    expect_out(mk(4'd10, RESP_SLVERR, 1'b1), 10);
    @(posedge clk_i); #1;
    b_valid_i = 1'b0; b_i = '0;
    lookup(4'd9, 0, 1'b0, 1'b0);
    expect_out(mk(4'd9, RESP_OKAY, 1'b0), 0);

    // Asynchronous reset while holding a response in Send.
    beat_in(mk(4'd11, RESP_SLVERR, 1'b0));
    lookup(4'd11, 0, 1'b0, 1'b0);
    @(negedge clk_i); #1;
    check("pre_rst_valid", 32'(b_valid_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(b_valid_o), 32'd0);
    check("arst_ready", 32'(b_ready_o), 32'd1);
    check("arst_b_o", 32'(b_o), 32'd0);
    check("arst_id", 32'(cnt_id_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); #1;
    check("post_rst_valid", 32'(b_valid_o), 32'd0);
    check("post_rst_ready", 32'(b_ready_o), 32'd1);
    beat_in(mk(4'd12, RESP_OKAY, 1'b0));
    lookup(4'd12, 0, 1'b0, 1'b0);
    expect_out(mk(4'd12, RESP_OKAY, 1'b0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
